// File: rtl/stage_4_pkg.sv
// stage_4_pkg: shared constants, FSM state type and helpers for the
// memory-access stage (stage_4) of the RV32I pipeline.
//   - RV32I opcodes for LOAD / STORE
//   - func_3 width/sign codes
//   - FSM state encoding (IDLE / BUSY)
//   - sign_extend(): sign-extends a byte or halfword to 32 bits
package stage_4_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
  localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
  localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
  localparam logic [2:0] F3_BU = 3'b100;  // LBU
  localparam logic [2:0] F3_HU = 3'b101;  // LHU

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // is_half = 0: extend v[7:0]; is_half = 1: extend v[15:0].
  function automatic logic [31:0] sign_extend(input logic [15:0] v, input logic is_half);
    return is_half ? {{16{v[15]}}, v} : {{24{v[7]}}, v[7:0]};
  endfunction

endpackage

// File: rtl/stage_4_if.sv
// stage_4_if: request/acknowledge data-memory bus used by stage_4.
//   mem_req   request (held while an access is outstanding)
//   mem_we    1 = write
//   mem_addr  word-aligned byte address
//   mem_wdata lane-replicated write data
//   mem_be    byte enables
//   mem_rdata read data, valid with mem_ack
//   mem_ack   completion
// master = the pipeline stage, slave = the memory.
interface stage_4_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/stage_4_load_align.sv
// stage_4_load_align: combinational load formatting.
//   rdata_i   raw 32-bit word from memory
//   addr_lo_i byte offset within the word (addr[1:0])
//   func_3_i  width/sign selector (LB/LBU/LH/LHU/LW)
//   data_o    lane-selected, sign/zero-extended result
// Halfwords use addr[1] only; unknown func_3 returns the raw word.
module stage_4_load_align
  import stage_4_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  func_3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = rdata_i;
    case (func_3_i)
      F3_B:    data_o = sign_extend({8'h00, byte_sel}, 1'b0);
      F3_BU:   data_o = {24'h0, byte_sel};
      F3_H:    data_o = sign_extend(half_sel, 1'b1);
      F3_HU:   data_o = {16'h0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/stage_4.sv
// stage_4: memory-access stage of the 5-stage RV32I pipeline.
// ALU results pass straight through to writeback with one cycle latency;
// loads/stores are issued on the req/ack bus (mem) and the stage stalls
// upstream while the access is outstanding.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_valid..i_op_type  execute-stage result bundle
//   stall               upstream must hold its inputs (state == BUSY)
//   mem                 data-memory bus (stage_4_if.master)
//   valid, wb_data, rd_num, wb_en   writeback bundle (valid is a pulse)
//   bus_err             one-cycle pulse when a bus access times out
//   misalign            one-cycle pulse on a trapped misaligned access
// Parameter TIMEOUT: cycles mem_req may stay unacknowledged (0 = never abort).
// Build option: define MISALIGN_TRAP_EN to trap misaligned half/word
// accesses instead of silently ignoring the low address bits.
module stage_4
  import stage_4_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [31:0]      i_alu_out,
  input  logic [31:0]      i_rs_2,
  input  logic [4:0]       i_rd_num,
  input  logic [6:0]       i_opcode,
  input  logic [2:0]       i_func_3,
  input  logic             i_op_type,
  output logic             stall,
  stage_4_if.master        mem,
  output logic             valid,
  output logic [31:0]      wb_data,
  output logic [4:0]       rd_num,
  output logic             wb_en,
  output logic             bus_err,
  output logic             misalign
);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  addr_lo_q;
  logic [2:0]  func_3_q;
  logic [4:0]  rd_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic        valid_q, wb_en_q, bus_err_q, misalign_q;
  logic [31:0] wb_data_q;
  logic [4:0]  rd_num_q;

  logic        start, trap, issue, ack_done, timeout_hit;
  logic [31:0] st_wdata, load_val;
  logic [3:0]  st_be;

  assign start       = (state_q == IDLE) && i_valid && i_op_type;
  assign issue       = start && !trap;
  assign ack_done    = (state_q == BUSY) && mem.mem_ack;
  // Abort on the edge where the no-ack count would reach TIMEOUT, so
  // mem_req is high for exactly TIMEOUT cycles.
  assign timeout_hit = (state_q == BUSY) && !mem.mem_ack && (TIMEOUT != 0)
                       && ((cnt_q + 32'd1) == TIMEOUT);

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    trap = 1'b0;
    if (start) begin
      if ((i_func_3 == F3_H || i_func_3 == F3_HU) && i_alu_out[0]) trap = 1'b1;
      if ((i_func_3 == F3_W) && (i_alu_out[1:0] != 2'b00))       trap = 1'b1;
    end
  end
`else
  assign trap = 1'b0;
`endif

  // Store lane formatting; loads also carry these enables on the bus.
  always_comb begin
    st_wdata = i_rs_2;
    st_be    = 4'b1111;
    case (i_func_3)
      F3_B: begin
        st_wdata = {4{i_rs_2[7:0]}};
        st_be    = 4'b0001 << i_alu_out[1:0];
      end
      F3_H: begin
        st_wdata = {2{i_rs_2[15:0]}};
        st_be    = i_alu_out[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  stage_4_load_align u_load_align (
    .rdata_i   (mem.mem_rdata),
    .addr_lo_i (addr_lo_q),
    .func_3_i  (func_3_q),
    .data_o    (load_val)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = BUSY;
      BUSY:    if (ack_done || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    stall       = (state_q == BUSY);
    mem.mem_req = (state_q == BUSY);
  end

  assign cnt_d = ((state_q == BUSY) && !mem.mem_ack) ? cnt_q + 32'd1 : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      addr_lo_q   <= '0;
      func_3_q    <= '0;
      rd_q        <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      valid_q     <= 1'b0;
      wb_data_q   <= '0;
      rd_num_q    <= '0;
      wb_en_q     <= 1'b0;
      bus_err_q   <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      valid_q    <= 1'b0;
      bus_err_q  <= 1'b0;
      misalign_q <= trap;
      if ((state_q == IDLE) && i_valid && !i_op_type) begin
        valid_q   <= 1'b1;
        wb_data_q <= i_alu_out;
        rd_num_q  <= i_rd_num;
        wb_en_q   <= (i_rd_num != 5'd0);
      end else if (trap) begin
        valid_q   <= 1'b1;
        wb_data_q <= '0;
        rd_num_q  <= i_rd_num;
        wb_en_q   <= 1'b0;
      end else if (issue) begin
        addr_lo_q   <= i_alu_out[1:0];
        func_3_q    <= i_func_3;
        rd_q        <= i_rd_num;
        mem_we_q    <= (i_opcode == OP_STORE);
        mem_addr_q  <= {i_alu_out[31:2], 2'b00};
        mem_wdata_q <= st_wdata;
        mem_be_q    <= st_be;
      end else if (ack_done) begin
        valid_q  <= 1'b1;
        rd_num_q <= rd_q;
        if (mem_we_q) begin
          wb_data_q <= '0;
          wb_en_q   <= 1'b0;
        end else begin
          wb_data_q <= load_val;
          wb_en_q   <= (rd_q != 5'd0);
        end
      end else if (timeout_hit) begin
        valid_q   <= 1'b1;
        bus_err_q <= 1'b1;
        wb_data_q <= '0;
        rd_num_q  <= rd_q;
        wb_en_q   <= 1'b0;
      end
    end
  end

  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_be    = mem_be_q;
  assign valid         = valid_q;
  assign wb_data       = wb_data_q;
  assign rd_num        = rd_num_q;
  assign wb_en         = wb_en_q;
  assign bus_err       = bus_err_q;
  assign misalign      = misalign_q;

endmodule

// File: tb/tb_stage_4.sv
// tb_stage_4: directed self-checking bench for stage_4 (TIMEOUT = 4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_stage_4;
  import stage_4_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [31:0] i_alu_out, i_rs_2;
  logic [4:0]  i_rd_num;
  logic [6:0]  i_opcode;
  logic [2:0]  i_func_3;
  logic        i_op_type;
  logic        stall, valid, wb_en, bus_err, misalign;
  logic [31:0] wb_data;
  logic [4:0]  rd_num;

  int checks = 0;
  int errors = 0;

  stage_4_if mem_bus ();

  stage_4 #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .i_alu_out (i_alu_out),
    .i_rs_2    (i_rs_2),
    .i_rd_num  (i_rd_num),
    .i_opcode  (i_opcode),
    .i_func_3  (i_func_3),
    .i_op_type (i_op_type),
    .stall     (stall),
    .mem       (mem_bus),
    .valid     (valid),
    .wb_data   (wb_data),
    .rd_num    (rd_num),
    .wb_en     (wb_en),
    .bus_err   (bus_err),
    .misalign  (misalign)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic drive(input logic v, input logic op, input logic [6:0] opc,
                       input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic [4:0] rd);
    i_valid   = v;
    i_op_type = op;
    i_opcode  = opc;
    i_func_3  = f3;
    i_alu_out = alu;
    i_rs_2    = rs2;
    i_rd_num  = rd;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 7'h0, 3'h0, 32'h0, 32'h0, 5'd0);
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 32'h0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_valid", valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_req", mem_bus.mem_req, 0);
    chk("rst_wb", {wb_en, bus_err, misalign, rd_num, wb_data[7:0]}, 0);
    chk("rst_be", mem_bus.mem_be, 0);

    // ALU pass-through, rd 5 then rd 0
    drive(1'b1, 1'b0, 7'h33, 3'h0, 32'h00001234, 32'h0, 5'd5);
    tick();
    $display("ALU rd5: valid=%0b wb_data=%h wb_en=%0b", valid, wb_data, wb_en);
    chk("alu_valid", valid, 1);
    chk("alu_data", wb_data, 32'h00001234);
    chk("alu_rd", rd_num, 5);
    chk("alu_wben", wb_en, 1);
    drive(1'b1, 1'b0, 7'h33, 3'h0, 32'h00001234, 32'h0, 5'd0);
    tick();
    $display("ALU rd0: valid=%0b wb_en=%0b", valid, wb_en);
    chk("alu0_valid", valid, 1);
    chk("alu0_wben", wb_en, 0);
    i_valid = 1'b0;
    tick();
    chk("alu_pulse", valid, 0);
    chk("alu_hold", wb_data, 32'h00001234);

    // LB at 0x103, two wait cycles
    drive(1'b1, 1'b1, OP_LOAD, F3_B, 32'h00000103, 32'h0, 5'd7);
    tick();
    chk("lb_addr", mem_bus.mem_addr, 32'h00000100);
    chk("lb_we", mem_bus.mem_we, 0);
    chk("lb_stall1", stall, 1);
    chk("lb_req", mem_bus.mem_req, 1);
    chk("lb_nvalid", valid, 0);
    tick();
    chk("lb_stall2", stall, 1);
    tick();
    chk("lb_stall3", stall, 1);
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = 32'h80FFFFFF;
    i_valid = 1'b0;
    tick();
    mem_bus.mem_ack = 1'b0;
    $display("LB: valid=%0b wb_data=%h wb_en=%0b", valid, wb_data, wb_en);
    chk("lb_stall_end", stall, 0);
    chk("lb_req_end", mem_bus.mem_req, 0);
    chk("lb_valid", valid, 1);
    chk("lb_data", wb_data, 32'hFFFFFF80);
    chk("lb_rd", rd_num, 7);
    chk("lb_wben", wb_en, 1);

    // LBU at 0x103, immediate ack
    drive(1'b1, 1'b1, OP_LOAD, F3_BU, 32'h00000103, 32'h0, 5'd7);
    tick();
    mem_bus.mem_ack = 1'b1;
    i_valid = 1'b0;
    tick();
    mem_bus.mem_ack = 1'b0;
    $display("LBU: valid=%0b wb_data=%h", valid, wb_data);
    chk("lbu_valid", valid, 1);
    chk("lbu_data", wb_data, 32'h00000080);

    // LH at 0x102, upper half sign-extended
    drive(1'b1, 1'b1, OP_LOAD, F3_H, 32'h00000102, 32'h0, 5'd8);
    tick();
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = 32'h80012345;
    i_valid = 1'b0;
    tick();
    mem_bus.mem_ack = 1'b0;
    $display("LH: wb_data=%h", wb_data);
    chk("lh_data", wb_data, 32'hFFFF8001);

    // SH at 0x202
    drive(1'b1, 1'b1, OP_STORE, F3_H, 32'h00000202, 32'hAAAABEEF, 5'd0);
    tick();
    $display("SH: we=%0b be=%b wdata=%h addr=%h", mem_bus.mem_we, mem_bus.mem_be,
             mem_bus.mem_wdata, mem_bus.mem_addr);
    chk("sh_we", mem_bus.mem_we, 1);
    chk("sh_be", mem_bus.mem_be, 4'b1100);
    chk("sh_wdata", mem_bus.mem_wdata, 32'hBEEFBEEF);
    chk("sh_addr", mem_bus.mem_addr, 32'h00000200);
    mem_bus.mem_ack = 1'b1;
    i_valid = 1'b0;
    tick();
    mem_bus.mem_ack = 1'b0;
    chk("sh_valid", valid, 1);
    chk("sh_wben", wb_en, 0);
    chk("sh_data", wb_data, 0);

    // SB at 0x101
    drive(1'b1, 1'b1, OP_STORE, F3_B, 32'h00000101, 32'h123456A5, 5'd0);
    tick();
    $display("SB: be=%b wdata=%h", mem_bus.mem_be, mem_bus.mem_wdata);
    chk("sb_be", mem_bus.mem_be, 4'b0010);
    chk("sb_wdata", mem_bus.mem_wdata, 32'hA5A5A5A5);
    mem_bus.mem_ack = 1'b1;
    i_valid = 1'b0;
    tick();
    mem_bus.mem_ack = 1'b0;
    chk("sb_valid", valid, 1);

    // Timeout on LW at 0x300 (TIMEOUT = 4)
    drive(1'b1, 1'b1, OP_LOAD, F3_W, 32'h00000300, 32'h0, 5'd9);
    tick();
    i_valid = 1'b0;
    chk("to_req1", mem_bus.mem_req, 1);
    tick();
    chk("to_req2", mem_bus.mem_req, 1);
    tick();
    chk("to_req3", mem_bus.mem_req, 1);
    tick();
    chk("to_req4", mem_bus.mem_req, 1);
    chk("to_noerr", bus_err, 0);
    tick();
    $display("TIMEOUT: bus_err=%0b valid=%0b wb_en=%0b wb_data=%h req=%0b",
             bus_err, valid, wb_en, wb_data, mem_bus.mem_req);
    chk("to_req_end", mem_bus.mem_req, 0);
    chk("to_err", bus_err, 1);
    chk("to_valid", valid, 1);
    chk("to_wben", wb_en, 0);
    chk("to_data", wb_data, 0);
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = 32'h11111111;
    tick();
    mem_bus.mem_ack = 1'b0;
    chk("late_valid", valid, 0);
    chk("late_err", bus_err, 0);
    chk("late_stall", stall, 0);
    chk("late_data", wb_data, 0);

    // Reset during BUSY
    drive(1'b1, 1'b1, OP_LOAD, F3_W, 32'h00000400, 32'h0, 5'd6);
    tick();
    chk("rb_stall", stall, 1);
    rst = 1'b1;
    i_valid = 1'b0;
    tick();
    rst = 1'b0;
    $display("RST mid-BUSY: req=%0b stall=%0b valid=%0b", mem_bus.mem_req, stall, valid);
    chk("rb_req", mem_bus.mem_req, 0);
    chk("rb_stall0", stall, 0);
    chk("rb_valid", valid, 0);
    chk("rb_addr", mem_bus.mem_addr, 0);
    drive(1'b1, 1'b0, 7'h13, 3'h0, 32'h00000055, 32'h0, 5'd3);
    tick();
    i_valid = 1'b0;
    chk("rb_alu_valid", valid, 1);
    chk("rb_alu_data", wb_data, 32'h00000055);
    chk("rb_alu_wben", wb_en, 1);
    tick();

    // LW at 0x101
    drive(1'b1, 1'b1, OP_LOAD, F3_W, 32'h00000101, 32'h0, 5'd4);
    mem_bus.mem_rdata = 32'hCAFEF00D;
    tick();
`ifdef MISALIGN_TRAP_EN
    i_valid = 1'b0;
    $display("LW misaligned (trap): req=%0b misalign=%0b valid=%0b", mem_bus.mem_req, misalign, valid);
    chk("mis_req", mem_bus.mem_req, 0);
    chk("mis_stall", stall, 0);
    chk("mis_pulse", misalign, 1);
    chk("mis_valid", valid, 1);
    chk("mis_wben", wb_en, 0);
    tick();
    chk("mis_pulse_end", misalign, 0);
`else
    chk("mis_addr", mem_bus.mem_addr, 32'h00000100);
    chk("mis_stall", stall, 1);
    mem_bus.mem_ack = 1'b1;
    i_valid = 1'b0;
    tick();
    mem_bus.mem_ack = 1'b0;
    $display("LW misaligned (no trap): wb_data=%h misalign=%0b", wb_data, misalign);
    chk("mis_data", wb_data, 32'hCAFEF00D);
    chk("mis_valid", valid, 1);
    chk("mis_wben", wb_en, 1);
    chk("mis_flag", misalign, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
